// File: rtl/mux_nx1_arb_if.sv
// Handshake bundle for the N:1 registered mux/arbiter.
// Producers drive the input side; the consumer drives out_ready.
interface mux_nx1_arb_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SEL_W-1:0]     out_src;

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_src
    );

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/mux_nx1_arb.sv
// N-input WIDTH-bit mux with one registered output stage.
// Explicit select (mode=0) or round-robin arbitration (mode=1).
module mux_nx1_arb #(
    parameter int N     = 4,
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    mux_nx1_arb_if.slave   bus
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic [SEL_W-1:0] last_q, last_d;

    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             xfer;

    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!bus.mode) begin
            if (int'(bus.sel) < N && bus.in_valid[bus.sel]) begin
                grant_vld = 1'b1;
                grant_idx = bus.sel;
            end
        end else begin
            // Search starts one past the last winner so nobody is skipped.
            for (int k = 1; k <= N; k++) begin
                idx = (int'(last_q) + k) % N;
                if (!grant_vld && bus.in_valid[SEL_W'(idx)]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(idx);
                end
            end
        end
    end

    assign xfer = load_en && grant_vld && !reset;

    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        if (xfer) begin
            out_data_d  = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
            if (bus.mode) begin
                last_d = grant_idx;
            end
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            last_q      <= SEL_W'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: doc/mux_nx1_arb.md
Name: mux_nx1_arb

Overview:
- Parametrised successor to the CPU's fixed 4:1 combinational selector: N-input, WIDTH-bit channel mux with one registered output stage and valid/ready handshakes on every input and on the output.
- Two run-time modes: explicit select (index driven by control logic) and round-robin arbitration across valid inputs.
- Used where several producers share one consumer, e.g. writeback-source merge or multi-master bus request funnel.

Parameters:
- N, 4, number of input channels (2..16).
- WIDTH, 32, data width per channel.
- SEL_W, $clog2(N), derived select/index width; not overridden.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = explicit select via sel; 1 = round-robin arbitration.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready, combinational, at most one bit high.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_src  output  SEL_W  index of channel that produced out_data.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports clk and reset.
- Reset values: out_valid=0, out_data=0, out_src=0, round-robin pointer last=N-1, so the first search starts at channel 0.
- load_en = !out_valid || out_ready. The output register accepts a new word when empty or draining the same cycle.
- Grant in mode 0: g = sel if sel < N and in_valid[sel]; otherwise no grant. sel >= N never grants and never raises any in_ready.
- Grant in mode 1: g = first i with in_valid[i]=1, searching last+1, last+2, ... cyclically modulo N. Wrap from N-1 to 0.
- in_ready[i] = load_en && grant exists && g==i. Purely combinational; no in_valid-to-in_ready dependency other than through the grant.
- Transfer on channel g when in_valid[g] && in_ready[g]. Next edge: out_data <= channel g data, out_src <= g, out_valid <= 1. If mode=1, last <= g.
- last updates only on a transfer in mode 1. Mode-0 transfers leave it unchanged.
- No input transfer while load_en=1: out_valid <= 0 when out_ready=1 drained the register; otherwise stays 0.
- Simultaneous drain and load: out_ready=1 with out_valid=1 and a grant gives back-to-back words, full throughput of 1 word/cycle.
- Stall: out_valid=1 && out_ready=0 → out_data and out_src held bit-stable, all in_ready=0, last unchanged.
- Latency: 1 cycle from input transfer to out_valid.
- mode or sel changes take effect combinationally on the next grant decision. A word already in the output register is unaffected.
- Round-robin fairness: with all N inputs continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0 with no channel skipped.
- Reset mid-operation: a held output word is discarded (out_valid=0 next cycle), last returns to N-1, and no in_ready is high during the reset cycle.
- Data path is pure selection, no arithmetic. Out-of-range channel bits do not exist since in_data is exactly N*WIDTH.

Test Plan:
- Reset, then mode=0, sel=2, in_valid=4'b0100, in_data ch2=32'hDEAD_BEEF, out_ready=1 → in_ready=4'b0100. Next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_src=2.
- mode=0, sel=1, in_valid[1]=0, others valid → in_ready=0, out_valid stays 0. Set sel=3 (N=4) with ch3 valid → grant ch3 next cycle.
- mode=1, all four valid, out_ready=1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3, one word per cycle.
- mode=1, in_valid=4'b1010, last=1 → grant 3, then 1, then 3. Channels 0 and 2 never receive in_ready.
- Output loaded with ch0=32'h1234_5678, out_ready=0 for 5 cycles with other inputs valid → out_data/out_src stable, in_ready=0. out_ready=1 → drain and reload in the same cycle.
- Assert reset while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_data=0. Then mode=1 with all valid → first grant is channel 0.
